// File: rtl/rs_int_pkg.sv
// rtl/rs_int_pkg.sv - shared widths, opcode names and CDB tag-match helper for the integer reservation station
package rs_int_pkg;

  localparam int RS_INT_DEPTH    = 4;
  localparam int RS_INT_ADDR_BUS = 2;
  localparam int ROB_ADDR_BUS    = 5;
  localparam int OPGEN_BUS       = 6;
  localparam int EXC_TYPE_BUS    = 3;

  typedef enum logic [OPGEN_BUS-1:0] {
    OPGEN_NOP = 6'd0,
    OPGEN_ADD = 6'd1,
    OPGEN_SUB = 6'd2,
    OPGEN_AND = 6'd3,
    OPGEN_OR  = 6'd4
  } opgen_e;

  // An operand is woken when it still waits on a tag and the broadcast carries that tag.
  function automatic logic cdb_hit(input logic                    is_ref,
                                   input logic [31:0]             opnd,
                                   input logic                    en,
                                   input logic [ROB_ADDR_BUS-1:0] tag);
    return en && is_ref && (opnd[ROB_ADDR_BUS-1:0] == tag);
  endfunction

endpackage

// File: rtl/rs_int_select.sv
// rtl/rs_int_select.sv - picks one ready entry as a one-hot grant (oldest-first when RS_INT_OLDEST_FIRST_EN is defined)
module rs_int_select
  import rs_int_pkg::*;
(
  input  logic [RS_INT_DEPTH-1:0]                      ready,
  input  logic [RS_INT_DEPTH-1:0][RS_INT_ADDR_BUS-1:0] age,
  output logic [RS_INT_DEPTH-1:0]                      grant,
  output logic                                         grant_valid
);

  assign grant_valid = |ready;

`ifdef RS_INT_OLDEST_FIRST_EN
  logic                       found;
  logic [RS_INT_ADDR_BUS-1:0] best_age;

  // Smallest age among ready entries wins; age 0 is the oldest live entry.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    best_age = '0;
    for (int i = 0; i < RS_INT_DEPTH; i++) begin
      if (ready[i] && (!found || age[i] < best_age)) begin
        found    = 1'b1;
        best_age = age[i];
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`else
  logic unused_age;
  assign unused_age = ^age;

  // Lowest-index ready entry wins; scanning downward lets the lowest hit overwrite.
  always_comb begin
    grant = '0;
    for (int i = RS_INT_DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rs_int.sv
// rtl/rs_int.sv - integer reservation station with CDB wakeup; RS_INT_OLDEST_FIRST_EN selects oldest-first issue
module rs_int
  import rs_int_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    int_wen,
  input  logic [ROB_ADDR_BUS-1:0] rob_addr_in,
  input  logic [EXC_TYPE_BUS-1:0] exception_type_in,
  input  logic [OPGEN_BUS-1:0]    opgen_in,
  input  logic                    operand_is_ref_1_in,
  input  logic                    operand_is_ref_2_in,
  input  logic [31:0]             operand_data_1_in,
  input  logic [31:0]             operand_data_2_in,
  output logic                    full,
  input  logic                    cdb_en,
  input  logic [ROB_ADDR_BUS-1:0] cdb_rob_addr,
  input  logic [31:0]             cdb_data,
  input  logic                    flush,
  input  logic                    fu_ready,
  output logic                    issue_valid,
  output logic [ROB_ADDR_BUS-1:0] issue_rob_addr,
  output logic [OPGEN_BUS-1:0]    issue_opgen,
  output logic [EXC_TYPE_BUS-1:0] issue_exception_type,
  output logic [31:0]             issue_operand_1,
  output logic [31:0]             issue_operand_2
);

  logic [RS_INT_DEPTH-1:0] valid;
  logic [RS_INT_DEPTH-1:0] ref_1;
  logic [RS_INT_DEPTH-1:0] ref_2;
  logic [ROB_ADDR_BUS-1:0] tag_q    [RS_INT_DEPTH];
  logic [OPGEN_BUS-1:0]    opgen_q  [RS_INT_DEPTH];
  logic [EXC_TYPE_BUS-1:0] exc_q    [RS_INT_DEPTH];
  logic [31:0]             data_1_q [RS_INT_DEPTH];
  logic [31:0]             data_2_q [RS_INT_DEPTH];

  logic [RS_INT_DEPTH-1:0] ready;
  logic [RS_INT_DEPTH-1:0] grant;
  logic                    grant_valid;
  logic [RS_INT_DEPTH-1:0] wr_set;
  logic [RS_INT_DEPTH-1:0] issue_clr;
  logic                    do_write;
  logic                    hit_1_in;
  logic                    hit_2_in;
  logic [RS_INT_DEPTH-1:0][RS_INT_ADDR_BUS-1:0] age_vec;

  assign full        = &valid;
  assign ready       = valid & ~ref_1 & ~ref_2;
  assign do_write    = int_wen && !full && !flush;
  assign issue_valid = grant_valid;
  assign issue_clr   = (grant_valid && fu_ready) ? grant : '0;
  assign hit_1_in    = cdb_hit(operand_is_ref_1_in, operand_data_1_in, cdb_en, cdb_rob_addr);
  assign hit_2_in    = cdb_hit(operand_is_ref_2_in, operand_data_2_in, cdb_en, cdb_rob_addr);

  rs_int_select u_select (
    .ready       (ready),
    .age         (age_vec),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Lowest free slot of the registered state receives the write; a slot freed this cycle is not reused yet.
  always_comb begin
    wr_set = '0;
    if (do_write) begin
      for (int i = RS_INT_DEPTH - 1; i >= 0; i--) begin
        if (!valid[i]) begin
          wr_set    = '0;
          wr_set[i] = 1'b1;
        end
      end
    end
  end

  // Route the granted entry onto the issue bus.
  always_comb begin
    issue_rob_addr       = '0;
    issue_opgen          = '0;
    issue_exception_type = '0;
    issue_operand_1      = '0;
    issue_operand_2      = '0;
    for (int i = 0; i < RS_INT_DEPTH; i++) begin
      if (grant[i]) begin
        issue_rob_addr       = tag_q[i];
        issue_opgen          = opgen_q[i];
        issue_exception_type = exc_q[i];
        issue_operand_1      = data_1_q[i];
        issue_operand_2      = data_2_q[i];
      end
    end
  end

  // Occupancy: flush empties everything, otherwise retire the issued entry and claim the written one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      valid <= (valid & ~issue_clr) | wr_set;
    end
  end

  // Payload capture and operand wakeup; a write coinciding with its producer's broadcast stores the value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_INT_DEPTH; i++) begin
      if (wr_set[i]) begin
        tag_q[i]    <= rob_addr_in;
        opgen_q[i]  <= opgen_in;
        exc_q[i]    <= exception_type_in;
        ref_1[i]    <= operand_is_ref_1_in && !hit_1_in;
        ref_2[i]    <= operand_is_ref_2_in && !hit_2_in;
        data_1_q[i] <= hit_1_in ? cdb_data : operand_data_1_in;
        data_2_q[i] <= hit_2_in ? cdb_data : operand_data_2_in;
      end else if (valid[i]) begin
        if (cdb_hit(ref_1[i], data_1_q[i], cdb_en, cdb_rob_addr)) begin
          ref_1[i]    <= 1'b0;
          data_1_q[i] <= cdb_data;
        end
        if (cdb_hit(ref_2[i], data_2_q[i], cdb_en, cdb_rob_addr)) begin
          ref_2[i]    <= 1'b0;
          data_2_q[i] <= cdb_data;
        end
      end
    end
  end

`ifdef RS_INT_OLDEST_FIRST_EN
  logic [RS_INT_DEPTH-1:0][RS_INT_ADDR_BUS-1:0] age;
  logic [RS_INT_DEPTH-1:0]                      live;
  logic [RS_INT_ADDR_BUS:0]                     live_cnt;
  logic [RS_INT_ADDR_BUS-1:0]                   grant_age;

  assign age_vec = age;
  assign live    = valid & ~issue_clr;

  // Entries surviving this edge and the age of the issued entry.
  always_comb begin
    live_cnt  = '0;
    grant_age = '0;
    for (int i = 0; i < RS_INT_DEPTH; i++) begin
      live_cnt = live_cnt + {{RS_INT_ADDR_BUS{1'b0}}, live[i]};
      if (grant[i]) grant_age = age[i];
    end
  end

  // Age = number of older live entries: a new entry goes behind all survivors, younger ones close the issue gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age <= '0;
    end else if (flush) begin
      age <= '0;
    end else begin
      for (int i = 0; i < RS_INT_DEPTH; i++) begin
        if (wr_set[i]) begin
          age[i] <= live_cnt[RS_INT_ADDR_BUS-1:0];
        end else if (valid[i] && grant_valid && fu_ready && age[i] > grant_age) begin
          age[i] <= age[i] - 1'b1;
        end
      end
    end
  end
`else
  assign age_vec = '0;
`endif

endmodule

// File: doc/rs_int.md
RS_INT -- requirements
Module: rs_int

Interface
REQ-001 SHALL have port clk input 1: sole clock, all state on rising edge.
REQ-002 SHALL have port rst input 1: asynchronous, active-low reset.
REQ-003 SHALL have port int_wen input 1: write enable from issue stage, one entry per asserted cycle.
REQ-004 SHALL have port rob_addr_in input ROB_ADDR_BUS: destination ROB tag of the written instruction.
REQ-005 SHALL have ports exception_type_in input EXC_TYPE_BUS and opgen_in input OPGEN_BUS: stored verbatim.
REQ-006 SHALL have ports operand_is_ref_1_in and operand_is_ref_2_in input 1 each: operand holds a ROB tag in its low ROB-address bits, not a value.
REQ-007 SHALL have ports operand_data_1_in and operand_data_2_in input 32 each: value, or tag when the ref bit is set.
REQ-008 SHALL have port full output 1: no free entry; feeds stall_request upstream.
REQ-009 SHALL have ports cdb_en input 1, cdb_rob_addr input ROB_ADDR_BUS, cdb_data input 32: result broadcast.
REQ-010 SHALL have port flush input 1: synchronous discard of all entries.
REQ-011 SHALL have ports fu_ready input 1 and issue_valid output 1: issue handshake to the integer ALU.
REQ-012 SHALL have ports issue_rob_addr, issue_opgen, issue_exception_type, issue_operand_1 and issue_operand_2 (outputs, widths as the matching inputs): the selected entry.

Function
REQ-013 SHALL hold RS_INT_DEPTH entries (default 4), each with valid, tag, opgen, exc type, and two operands each with a ref bit and 32-bit data.
REQ-014 SHALL drive full = all entries valid, combinationally from state only.
REQ-015 SHALL, when int_wen && !full && !flush, write the lowest-index free entry at the clock edge; int_wen while full SHALL be ignored without any state change, even if an issue frees an entry in the same cycle.
REQ-016 SHALL, on cdb_en, clear the ref bit and load cdb_data into every valid operand whose ref bit is set and whose tag equals cdb_rob_addr.
REQ-017 SHALL apply REQ-016 to operands being written in the same cycle, so a write coinciding with its producer's broadcast stores a ready value.
REQ-018 SHALL treat an entry as ready when valid and both ref bits are clear; ready is evaluated on registered state, so an entry written or woken in cycle N can issue no earlier than N+1.
REQ-019 SHALL drive issue_valid = any ready entry, with the issue_* fields combinationally from the selected entry; fields are don't-care when issue_valid is 0.
REQ-020 SHALL free the selected entry at the edge where issue_valid && fu_ready; issue_* SHALL be held stable while issue_valid && !fu_ready unless an older entry becomes ready.
REQ-021 SHALL give flush priority over write, wakeup and issue: after a flush edge all entries are invalid.
REQ-022 SHALL pass exception_type through unchanged and SHALL NOT alter readiness on it.

Reset
REQ-023 SHALL, while rst is low, clear every valid bit and age state asynchronously, so full=0 and issue_valid=0; the reset value of other entry fields is don't-care.

Configuration
REQ-024 SHALL, with RS_INT_OLDEST_FIRST_EN defined, select the oldest ready entry by write order using per-entry age state that is updated on write, issue and flush.
REQ-025 SHALL, without RS_INT_OLDEST_FIRST_EN, select the lowest-index ready entry and instantiate no age state.

Structure
REQ-026 SHALL take RS_INT_DEPTH and RS_INT_ADDR_BUS from a shared rs.v header; ROB_ADDR_BUS, OPGEN_BUS and EXC_TYPE_BUS come from the existing shared headers.
REQ-027 SHALL place entry selection, including both configuration variants, in sub-module rs_int_select, which maps ready and age vectors to a one-hot grant and a grant_valid.

Verification
REQ-028 Bench SHALL cover: write ADD with both operands as values 5 and 7, tag 3, fu_ready=1 -> issue_valid next cycle with operands 5 and 7 and rob_addr 3, and entry freed after one cycle.
REQ-029 Bench SHALL cover: write with op1 ref tag 9, then cdb_en tag 9 data 0xDEAD two cycles later -> issue_valid rises the cycle after the broadcast with operand_1=0xDEAD.
REQ-030 Bench SHALL cover: write with ref tag 2 in the same cycle as cdb tag 2 data 0x11 -> entry ready next cycle with operand 0x11.
REQ-031 Bench SHALL cover: fill 4 entries with fu_ready=0 -> full=1; a 5th int_wen is ignored; after one issue, full drops and the next write lands.
REQ-032 Bench SHALL cover: entries at idx1 (older) and idx0 (younger) both ready -> idx1 issues when RS_INT_OLDEST_FIRST_EN is defined, idx0 when it is not.
REQ-033 Bench SHALL cover: flush concurrent with int_wen and a pending issue -> all entries empty next cycle and no issue handshake; rst low mid-operation -> full=0 and issue_valid=0 immediately.
